// File: rtl/note_pkg.sv
// Shared encodings for the note-event path: letter codes, silence, one-hot
// durations, FSM state type and a helper that recognises a playable letter.
package note_pkg;

  typedef logic [7:0] note_code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAND = 2'd1,
    HOLD = 2'd2
  } nee_state_t;

  localparam note_code_t SILENCE = 8'h00;

  localparam logic [3:0] LET_G = 4'h8;
  localparam logic [3:0] LET_A = 4'hA;
  localparam logic [3:0] LET_B = 4'hB;
  localparam logic [3:0] LET_C = 4'hC;
  localparam logic [3:0] LET_D = 4'hD;
  localparam logic [3:0] LET_E = 4'hE;
  localparam logic [3:0] LET_F = 4'hF;

  localparam logic [3:0] DUR_EIGHTH  = 4'b0001;
  localparam logic [3:0] DUR_QUARTER = 4'b0010;
  localparam logic [3:0] DUR_HALF    = 4'b0100;
  localparam logic [3:0] DUR_WHOLE   = 4'b1000;

  // Any letter not in the table (including SILENCE's 0) counts as silence.
  function automatic logic is_pitch_letter(input logic [3:0] letter);
    logic r;
    case (letter)
      LET_G, LET_A, LET_B, LET_C, LET_D, LET_E, LET_F: r = 1'b1;
      default:                                         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/duration_quantizer.sv
// Combinational: held-frame count -> one-hot note duration (eighth..whole).
// Zero latency; no handshake, output follows input.
module duration_quantizer
  import note_pkg::*;
#(
  parameter int FRAMES_PER_EIGHTH = 4,
  parameter int CNT_W             = $clog2(8 * FRAMES_PER_EIGHTH + 1)
) (
  input  logic [CNT_W-1:0] i_length,
  output logic [3:0]       o_duration
);

  localparam int QW = CNT_W + 2;
  localparam logic [QW-1:0] THREE_E = QW'(3 * FRAMES_PER_EIGHTH);
  localparam logic [QW-1:0] SIX_E   = QW'(6 * FRAMES_PER_EIGHTH);

  logic [QW-1:0] w_len;
  logic [QW-1:0] w_len_x2;

  assign w_len    = {2'b00, i_length};
  assign w_len_x2 = {1'b0, i_length, 1'b0};

  // Thresholds sit halfway between nominal lengths: 1.5E, 3E, 6E.
  always_comb begin
    o_duration = DUR_WHOLE;
    if (w_len_x2 < THREE_E)   o_duration = DUR_EIGHTH;
    else if (w_len < THREE_E) o_duration = DUR_QUARTER;
    else if (w_len < SIX_E)   o_duration = DUR_HALF;
  end

endmodule

// File: rtl/note_event_encoder.sv
// Debounces per-frame pitch codes into {note, duration} events; note_dec is registered,
// one cycle after the ending strobe, no back-pressure. NOTE_SPLIT_EN: split long notes into wholes.
module note_event_encoder
  import note_pkg::*;
#(
  parameter int FRAMES_PER_EIGHTH = 4,
  parameter int MIN_FRAMES        = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pitch_valid,
  input  logic [7:0] i_pitch_code,
  output logic [7:0] o_note,
  output logic [3:0] o_duration,
  output logic       o_note_dec
);

  localparam int CNT_W = $clog2(8 * FRAMES_PER_EIGHTH + 1);
  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(8 * FRAMES_PER_EIGHTH);
  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_FRAMES);
  localparam logic [CNT_W-1:0] LEN_ONE = CNT_W'(1);
  localparam nee_state_t LOAD_STATE = (MIN_FRAMES == 1) ? HOLD : CAND;

  nee_state_t       r_state;
  note_code_t       r_cand;
  logic [CNT_W-1:0] r_length;
  logic [7:0]       r_note;
  logic [3:0]       r_duration;
  logic             r_note_dec;

  logic             w_is_pitch;
  logic             w_same;
  logic [CNT_W-1:0] w_len_inc;
  logic [3:0]       w_dur;

  assign w_is_pitch = is_pitch_letter(i_pitch_code[7:4]);
  assign w_same     = w_is_pitch && (i_pitch_code == r_cand);
  assign w_len_inc  = r_length + LEN_ONE;

  duration_quantizer #(
    .FRAMES_PER_EIGHTH(FRAMES_PER_EIGHTH),
    .CNT_W            (CNT_W)
  ) u_quant (
    .i_length  (r_length),
    .o_duration(w_dur)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_cand     <= SILENCE;
      r_length   <= '0;
      r_note     <= SILENCE;
      r_duration <= '0;
      r_note_dec <= 1'b0;
    end else begin
      r_note_dec <= 1'b0;
      if (i_pitch_valid) begin
        case (r_state)
          IDLE: begin
            if (w_is_pitch) begin
              r_cand   <= i_pitch_code;
              r_length <= LEN_ONE;
              r_state  <= LOAD_STATE;
            end
          end
          CAND: begin
            if (!w_is_pitch) begin
              r_length <= '0;
              r_state  <= IDLE;
            end else if (w_same) begin
              r_length <= w_len_inc;
              if (w_len_inc >= MIN_LEN) r_state <= HOLD;
            end else begin
              r_cand   <= i_pitch_code;
              r_length <= LEN_ONE;
            end
          end
          HOLD: begin
            if (w_same) begin
`ifdef NOTE_SPLIT_EN
              if (w_len_inc == LEN_MAX) begin
                r_note     <= r_cand;
                r_duration <= DUR_WHOLE;
                r_note_dec <= 1'b1;
                r_length   <= '0;
              end else begin
                r_length <= w_len_inc;
              end
`else
              if (r_length != LEN_MAX) r_length <= w_len_inc;
`endif
            end else begin
              // A zero remainder only arises right after a split and is dropped.
              if (r_length != '0) begin
                r_note     <= r_cand;
                r_duration <= w_dur;
                r_note_dec <= 1'b1;
              end
              if (w_is_pitch) begin
                r_cand   <= i_pitch_code;
                r_length <= LEN_ONE;
                r_state  <= LOAD_STATE;
              end else begin
                r_length <= '0;
                r_state  <= IDLE;
              end
            end
          end
          default: begin
            r_length <= '0;
            r_state  <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_note     = r_note;
  assign o_duration = r_duration;
  assign o_note_dec = r_note_dec;

endmodule
